// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants, segment patterns and BCD split for the stopwatch display.
package stopwatch_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;
  localparam logic [5:0] MAX_SEC_MIN = 6'd59;
  localparam logic [3:0] CODE_DASH = 4'hA;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  // {tens, ones}; values above 59 become a dash pair
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = v >= 6'd50 ? 4'd5 : v >= 6'd40 ? 4'd4 : v >= 6'd30 ? 4'd3 :
        v >= 6'd20 ? 4'd2 : v >= 6'd10 ? 4'd1 : 4'd0;
    r = v - 6'(t) * 6'd10;
    return v > MAX_SEC_MIN ? {CODE_DASH, CODE_DASH} : {t, r[3:0]};
  endfunction
endpackage

// File: rtl/stopwatch_display_seven_seg_decoder.sv
// seven_seg_decoder: BCD code to active-high {g,f,e,d,c,b,a}; 4'hA is dash, other codes above 9 are dark.
module seven_seg_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'hA:    seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: shadows MM:SS from the time counter and scans it onto a 4-digit 7-segment display.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blank,
  output logic [6:0] segments,
  output logic       dp,
  output logic [3:0] anodes
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0] digit_idx_q, digit_idx_d;
  logic [5:0] shadow_min_q, shadow_min_d, shadow_sec_q, shadow_sec_d;
  logic load_pending_q, load_pending_d;
  logic [6:0] segments_q, segments_d;
  logic dp_q, dp_d;
  logic [3:0] anodes_q, anodes_d;
  logic wrap, load;
  logic [7:0] min_bcd, sec_bcd;
  logic [3:0] code;
  logic [6:0] pat;
  always_comb begin
    wrap = refresh_cnt_q == CW'(REFRESH_DIV - 1);
    load = load_pending_q | (wrap && digit_idx_q == DIG_MIN_TENS);
    refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
    digit_idx_d = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    shadow_min_d = load ? minutes : shadow_min_q;
    shadow_sec_d = load ? seconds : shadow_sec_q;
    load_pending_d = 1'b0;
    // the post-reset load is shown immediately so the first lit digit already carries live data
    min_bcd = to_bcd(load_pending_q ? minutes : shadow_min_q);
    sec_bcd = to_bcd(load_pending_q ? seconds : shadow_sec_q);
    code = digit_idx_q == DIG_SEC_ONES ? sec_bcd[3:0] :
           digit_idx_q == DIG_SEC_TENS ? sec_bcd[7:4] :
           digit_idx_q == DIG_MIN_ONES ? min_bcd[3:0] : min_bcd[7:4];
  end
  seven_seg_decoder u_dec (.code(code), .seg(pat));
  always_comb begin
    segments_d = (blank ? SEG_OFF : pat) ^ {7{SEG_ACTIVE_LOW}};
    dp_d = (!blank && digit_idx_q == DIG_MIN_ONES) ^ SEG_ACTIVE_LOW;
    anodes_d = (blank ? 4'b0000 : 4'b0001 << digit_idx_q) ^ {4{AN_ACTIVE_LOW}};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      digit_idx_q <= '0;
      shadow_min_q <= '0;
      shadow_sec_q <= '0;
      load_pending_q <= 1'b1;
      segments_q <= {7{SEG_ACTIVE_LOW}};
      dp_q <= SEG_ACTIVE_LOW;
      anodes_q <= {4{AN_ACTIVE_LOW}};
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q <= digit_idx_d;
      shadow_min_q <= shadow_min_d;
      shadow_sec_q <= shadow_sec_d;
      load_pending_q <= load_pending_d;
      segments_q <= segments_d;
      dp_q <= dp_d;
      anodes_q <= anodes_d;
    end
  end
  assign segments = segments_q;
  assign dp = dp_q;
  assign anodes = anodes_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed scan checks of stopwatch_display with REFRESH_DIV=4, active-low pins.
module tb_stopwatch_display;
  logic clock = 1'b0, reset = 1'b1, blank = 1'b0;
  logic [5:0] minutes = 6'd12, seconds = 6'd34;
  logic [6:0] segments;
  logic dp;
  logic [3:0] anodes;
  int checks = 0, failures = 0;
  localparam int DASH = 10;
  localparam logic [6:0] P [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                     7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};
  stopwatch_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .minutes(minutes), .seconds(seconds), .blank(blank),
    .segments(segments), .dp(dp), .anodes(anodes)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one scan starting on the first cycle digit 0 is lit; d0..d3 index P for sec ones..min tens
  task automatic run_scan(input string tag, input int d0, input int d1, input int d2, input int d3,
                          input logic [5:0] nm, input logic [5:0] ns,
                          input int b_on, input int b_off, input int n);
    int d [4];
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < n; i++) begin
      ea = blank ? 4'hF : ~(4'b0001 << (i / 4));
      es = blank ? 7'h7F : ~P[d[i/4]];
      ed = blank ? 1'b1 : (i / 4 != 2);
      check($sformatf("%s_an%0d", tag, i), {28'h0, anodes}, {28'h0, ea});
      check($sformatf("%s_seg%0d", tag, i), {25'h0, segments}, {25'h0, es});
      check($sformatf("%s_dp%0d", tag, i), {31'h0, dp}, {31'h0, ed});
      if (i == 5) begin
        minutes = nm;
        seconds = ns;
      end
      blank = i >= b_on && i < b_off;
      @(negedge clock);
    end
  endtask
  initial begin
    repeat (2) @(negedge clock);
    check("rst_an", {28'h0, anodes}, 32'hF);
    check("rst_seg", {25'h0, segments}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'h1);
    reset = 1'b0;
    @(negedge clock);
    run_scan("s1234", 4, 3, 2, 1, 6'd12, 6'd35, 16, 16, 16);
    run_scan("s1235", 5, 3, 2, 1, 6'd59, 6'd0, 16, 16, 16);
    run_scan("s5900", 0, 0, 9, 5, 6'd0, 6'd59, 16, 16, 16);
    run_scan("s0059", 9, 5, 0, 0, 6'd63, 6'd7, 16, 16, 16);
    run_scan("s6307", 7, 0, DASH, DASH, 6'd21, 6'd46, 16, 16, 16);
    run_scan("blk_a", 6, 4, 1, 2, 6'd21, 6'd46, 8, 16, 16);
    run_scan("blk_b", 6, 4, 1, 2, 6'd30, 6'd5, 0, 12, 16);
    run_scan("s3005", 5, 0, 0, 3, 6'd30, 6'd5, 16, 16, 10);
    reset = 1'b1;
    minutes = 6'd7;
    seconds = 6'd48;
    @(negedge clock);
    check("mid_rst_an", {28'h0, anodes}, 32'hF);
    check("mid_rst_seg", {25'h0, segments}, 32'h7F);
    check("mid_rst_dp", {31'h0, dp}, 32'h1);
    reset = 1'b0;
    @(negedge clock);
    run_scan("s0748", 8, 4, 7, 0, 6'd7, 6'd48, 16, 16, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Reader side of the stopwatch time bus: samples the `minutes`/`seconds` binary count from the time counter.
- Converts each value to two BCD digits.
- Time-multiplexes four digits onto a common-anode 7-segment display as MM.SS.
- Sits between the time counter and the board display pins; one clock domain shared with the counter.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2); sim uses 4.
- SEG_ACTIVE_LOW, 1, 1 = segment/dp pins driven low to light.
- AN_ACTIVE_LOW, 1, 1 = anode pins driven low to enable a digit.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- minutes  in  6  binary minutes from time counter, legal 0..59.
- seconds  in  6  binary seconds from time counter, legal 0..59.
- blank  in  1  1 = all digits dark; scan timing keeps running.
- segments  out  7  {g,f,e,d,c,b,a} for the active digit, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point for the active digit, polarity per SEG_ACTIVE_LOW.
- anodes  out  4  one-hot digit enable, polarity per AN_ACTIVE_LOW; bit0 = seconds ones, bit1 = seconds tens, bit2 = minutes ones, bit3 = minutes tens.

Behaviour:
- State: refresh_cnt (ceil(log2 REFRESH_DIV) bits), digit_idx (2 bits), shadow_min/shadow_sec (6 bits each), load_pending (1 bit), registered outputs.
- Reset state:
  - refresh_cnt=0, digit_idx=0, shadow values 0, load_pending=1.
  - All digits off: anodes inactive (4'b1111 when AN_ACTIVE_LOW), segments off, dp off.
- Refresh: refresh_cnt increments each cycle. At REFRESH_DIV-1 it wraps to 0 and digit_idx advances 0->1->2->3->0.
- Shadow load (anti-tearing):
  - shadow_min/shadow_sec capture minutes/seconds on the cycle digit_idx wraps 3->0.
  - They also capture on the first cycle after reset release (load_pending=1; load_pending then clears).
  - Inputs are ignored at all other times.
- BCD: tens = value/10, ones = value%10, using a compare/subtract chain, no divider. 59 -> 5,9; 0 -> 0,0; 10 -> 1,0.
- Out-of-range: a shadow value of 60..63 shows dash (g only) on both digits of that pair; the other pair is unaffected.
- Leading zeros are displayed (00.00 after reset).
- dp is lit only while digit_idx=2, giving the MM.SS separator.
- Output latency: segments/dp/anodes are registered. They reflect digit_idx and shadow values one cycle after those change, so the digit switch is visible one cycle after the refresh_cnt wrap.
- Exactly one anode is active at any time unless blank=1 or reset is asserted. No two-anode overlap cycle is permitted.
- blank:
  - Registered with the same 1-cycle latency.
  - When 1: anodes all inactive, segments off, dp off.
  - refresh_cnt, digit_idx and shadow loading continue unchanged.
- Reset mid-scan: the next edge returns everything to the reset state. The scan restarts at digit 0 with a fresh shadow load on the first non-reset cycle.
- Simultaneous wrap 3->0 and input change: the value present on the load cycle is captured.
- Polarity: all logic is active-high internally; the XOR/invert happens only at the output registers per parameter.

Decomposition:
- Package stopwatch_pkg holds:
  - NUM_DIGITS=4.
  - Digit index constants DIG_SEC_ONES/DIG_SEC_TENS/DIG_MIN_ONES/DIG_MIN_TENS.
  - 7-bit active-high segment patterns SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - MAX_SEC_MIN=59.
- Sub-module seven_seg_decoder: 4-bit BCD code (code 4'hA = dash, others >9 = off) -> 7-bit active-high pattern. Combinational, instantiated once after the digit select mux.

Test Plan:
- Reset then release, REFRESH_DIV=4, minutes=12, seconds=34:
  - First post-reset output cycle: anodes=4'b1110, segments=~SEG_4.
  - Then every 4 cycles: anodes 1101/~SEG_3, 1011/~SEG_2 with dp=0, 0111/~SEG_1.
  - Then the sequence repeats.
- Tearing: change seconds 34->35 while digit_idx=1:
  - Remaining digits of the current scan still show 34.
  - 35 appears only from the next digit 0 (shadow load at the 3->0 wrap).
- Boundaries: minutes=59, seconds=0 -> digits 5,9,0,0. minutes=0, seconds=59 -> 0,0,5,9.
- Out-of-range: minutes=63, seconds=7 -> minutes digits SEG_DASH, seconds digits 0,7.
- blank=1 for 20 cycles mid-scan:
  - anodes=4'b1111 and segments=7'b1111111 one cycle after assertion.
  - On deassert, the digit shown matches the uninterrupted scan position.
- Reset pulse while digit_idx=2: next cycle all outputs off, then the scan restarts at anodes=4'b1110 with freshly sampled values.
